// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit.
//   Iterative radix-2 engine: shift-add multiply and restoring divide. It takes
//   one launch edge, 32 step edges and one fix-up edge that writes HI/LO.
//   MTHI/MTLO write HI/LO directly while the unit is idle.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   i_start  - operation request (ignored unless idle)
//   i_op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   i_a      - rs operand (multiplicand / dividend / MTHI-MTLO source)
//   i_b      - rt operand (multiplier / divisor)
//   i_flush  - abort any in-flight operation, suppress the HI/LO write
//   o_busy   - high while an iterative operation is in flight
//   o_done   - one-cycle pulse after the HI/LO write of a mul/div
//   o_hi     - HI register
//   o_lo     - LO register
// Configuration:
//   MULDIV_FAST_MUL_EN - when defined, MULT/MULTU complete in a single cycle
//                        with a combinational multiplier. Divides are unchanged.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [31:0] acc_reg;   // product high half / partial remainder
  logic [31:0] q_reg;     // multiplier shifting out / quotient shifting in
  logic [31:0] m_reg;     // multiplicand or divisor magnitude
  logic        is_div_reg, neg_a_reg, neg_b_reg, div0_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        launch, fix_write, fast_mul, mt_hi, mt_lo;

  // Operand magnitudes. Even opcodes are the signed variants.
  logic        op_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign op_signed = ~i_op[0];
  assign a_neg     = op_signed & i_a[31];
  assign b_neg     = op_signed & i_b[31];
  assign a_mag     = a_neg ? -i_a : i_a;
  assign b_mag     = b_neg ? -i_b : i_b;

  // Radix-2 step datapath.
  logic [32:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : 33'd0);
  assign div_shift = {acc_reg, q_reg[31]};
  assign div_diff  = div_shift - {1'b0, m_reg};

  // Sign fix-up. With a zero divisor the quotient is left as all ones; the
  // remainder then holds |a|, and restoring the dividend's sign yields raw a.
  logic [63:0] prod_res;
  logic [31:0] quot_res, rem_res, fix_hi, fix_lo;
  assign prod_res = (neg_a_reg ^ neg_b_reg) ? -{acc_reg, q_reg} : {acc_reg, q_reg};
  assign quot_res = (div0_reg || !(neg_a_reg ^ neg_b_reg)) ? q_reg : -q_reg;
  assign rem_res  = neg_a_reg ? -acc_reg : acc_reg;
  assign fix_hi   = is_div_reg ? rem_res  : prod_res[63:32];
  assign fix_lo   = is_div_reg ? quot_res : prod_res[31:0];

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_mag, fast_prod;
  assign fast_mag  = {32'd0, a_mag} * {32'd0, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    fix_write  = 1'b0;
    fast_mul   = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            mt_hi = (i_op == OP_MTHI);
            mt_lo = (i_op == OP_MTLO);
            if (!i_op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
              if (!i_op[1]) begin
                fast_mul = 1'b1;
              end else begin
                launch     = 1'b1;
                state_next = RUN;
              end
`else
              launch     = 1'b1;
              state_next = RUN;
`endif
            end
          end
        end
        RUN: begin
          if (cnt_reg == 6'd31) state_next = FIX;
        end
        FIX: begin
          fix_write  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= fix_write | fast_mul;
      if (i_flush || launch) cnt_reg <= 6'd0;
      else if (state_reg == RUN) cnt_reg <= cnt_reg + 6'd1;
      if (fix_write) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end
      if (mt_hi) hi_reg <= i_a;
      if (mt_lo) lo_reg <= i_a;
`ifdef MULDIV_FAST_MUL_EN
      if (fast_mul) {hi_reg, lo_reg} <= fast_prod;
`endif
    end
  end

  // Datapath registers need no reset: they are always loaded on launch.
  always_ff @(posedge clk) begin
    if (launch) begin
      acc_reg    <= 32'd0;
      q_reg      <= i_op[1] ? a_mag : b_mag;
      m_reg      <= i_op[1] ? b_mag : a_mag;
      is_div_reg <= i_op[1];
      neg_a_reg  <= a_neg;
      neg_b_reg  <= b_neg;
      div0_reg   <= (i_b == 32'd0);
    end else if (state_reg == RUN) begin
      if (is_div_reg) begin
        if (!div_diff[32]) begin
          acc_reg <= div_diff[31:0];
          q_reg   <= {q_reg[30:0], 1'b1};
        end else begin
          acc_reg <= div_shift[31:0];
          q_reg   <= {q_reg[30:0], 1'b0};
        end
      end else begin
        acc_reg <= mul_sum[32:1];
        q_reg   <= {mul_sum[0], q_reg[31:1]};
      end
    end
  end

  assign o_busy = (state_reg != IDLE);
  assign o_done = done_reg;
  assign o_hi   = hi_reg;
  assign o_lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// plain-arithmetic reference model (default build, iterative multiply).
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_a(i_a),
    .i_b(i_b), .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op and wait for o_done. lat = edges after E0 until done is seen
  // (-1 on timeout); busy_ok = busy held high until done, then low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok,
                        output logic [31:0] hi, output logic [31:0] lo);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_a = $urandom; i_b = $urandom;
    lat = -1;
    busy_ok = o_busy;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (o_done) begin
        lat = n;
        if (o_busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (o_busy !== 1'b1) busy_ok = 1'b0;
    end
    hi = o_hi; lo = o_lo;
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d", op, a, b, hi, lo, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b1; i_flush = 1'b0; i_op = 3'd4; i_a = 32'hFFFF_FFFF; i_b = 32'd0;
    tick(); tick();
    rst = 1'b0; i_start = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    n_cmp++; if (o_hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%08h exp=0", o_hi); end
    n_cmp++; if (o_lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%08h exp=0", o_lo); end
  endtask

  task automatic test_mul;
    logic [2:0]  ops [2]  = '{3'd1, 3'd0};
    logic [31:0] as  [2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [31:0] bs  [2]  = '{32'hFFFF_FFFF, 32'd7};
    logic [2:0]  op;
    logic [31:0] a, b, eh, el, hi, lo;
    logic        bok;
    int          lat;
    for (int k = 0; k < 10; k++) begin
      if (k < 2) begin op = ops[k]; a = as[k]; b = bs[k]; end
      else begin
        op = 3'($urandom_range(0, 1));
        a = (k == 2) ? 32'h8000_0000 : $urandom;
        b = $urandom;
      end
      model(op, a, b, eh, el);
      run_op(op, a, b, lat, bok, hi, lo);
      n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL mul_hi op=%0d a=%08h b=%08h got=%08h exp=%08h", op, a, b, hi, eh); end
      n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL mul_lo op=%0d a=%08h b=%08h got=%08h exp=%08h", op, a, b, lo, el); end
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL mul_busy got=%b exp=1", bok); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] bs  [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [2:0]  op;
    logic [31:0] a, b, eh, el, hi, lo;
    logic        bok;
    int          lat;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) begin op = ops[k]; a = as[k]; b = bs[k]; end
      else begin
        op = 3'($urandom_range(2, 3));
        a = $urandom;
        b = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : ((k % 3 == 1) ? -32'($urandom_range(1, 20)) : $urandom);
      end
      model(op, a, b, eh, el);
      run_op(op, a, b, lat, bok, hi, lo);
      n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL div_hi op=%0d a=%08h b=%08h got=%08h exp=%08h", op, a, b, hi, eh); end
      n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL div_lo op=%0d a=%08h b=%08h got=%08h exp=%08h", op, a, b, lo, el); end
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency got=%0d exp=33", lat); end
      n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL div_busy got=%b exp=1", bok); end
    end
  endtask

  task automatic test_mt_and_noop;
    logic [31:0] v, hi_old, lo_old;
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      i_op = (k % 2 == 0) ? 3'd4 : 3'd5; i_a = v; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      $display("mt op=%0d a=%08h -> hi=%08h lo=%08h", i_op, v, o_hi, o_lo);
      if (k % 2 == 0) begin
        n_cmp++; if (o_hi !== v) begin n_bad++; $display("FAIL mthi got=%08h exp=%08h", o_hi, v); end
      end else begin
        n_cmp++; if (o_lo !== v) begin n_bad++; $display("FAIL mtlo got=%08h exp=%08h", o_lo, v); end
      end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mt_busy got=%b exp=0", o_busy); end
      tick();
      n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL mt_done got=%b exp=0", o_done); end
    end
    for (int k = 6; k <= 7; k++) begin
      hi_old = o_hi; lo_old = o_lo;
      i_op = 3'(k); i_a = $urandom; i_b = $urandom; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      $display("noop op=%0d -> hi=%08h lo=%08h busy=%b done=%b", k, o_hi, o_lo, o_busy, o_done);
      n_cmp++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_bad++; $display("FAIL noop_ctrl got=%b%b exp=00", o_busy, o_done); end
      n_cmp++; if (o_hi !== hi_old || o_lo !== lo_old) begin n_bad++; $display("FAIL noop_hilo got=%08h_%08h exp=%08h_%08h", o_hi, o_lo, hi_old, lo_old); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] hi_old, lo_old;
    logic        saw;
    i_op = 3'd4; i_a = 32'h1234_5678; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    lo_old = o_lo;
    i_op = 3'd3; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    tick();                                        // E0
    i_start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    i_op = 3'd5; i_a = 32'hDEAD_BEEF; i_start = 1'b1;
    tick();                                        // E5: ignored MTLO
    i_start = 1'b0;
    n_cmp++; if (o_lo !== lo_old) begin n_bad++; $display("FAIL flush_mtlo_ignored got=%08h exp=%08h", o_lo, lo_old); end
    for (int e = 6; e <= 10; e++) tick();
    i_flush = 1'b1;
    tick();                                        // E11 samples flush
    i_flush = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b exp=0", o_busy); end
    saw = 1'b0;
    for (int n = 0; n < 40; n++) begin tick(); if (o_done) saw = 1'b1; end
    $display("flush run -> hi=%08h lo=%08h done_seen=%b", o_hi, o_lo, saw);
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL flush_done got=%b exp=0", saw); end
    n_cmp++; if (o_hi !== 32'h1234_5678) begin n_bad++; $display("FAIL flush_hi got=%08h exp=12345678", o_hi); end
    n_cmp++; if (o_lo !== lo_old) begin n_bad++; $display("FAIL flush_lo got=%08h exp=%08h", o_lo, lo_old); end

    // Flush together with start while idle: nothing starts.
    i_op = 3'd3; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1; i_flush = 1'b1;
    tick();
    i_start = 1'b0; i_flush = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy got=%b exp=0", o_busy); end

    // Flush landing on the write edge.
    hi_old = o_hi; lo_old = o_lo;
    i_op = 3'd3; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    tick();                                        // E0
    i_start = 1'b0;
    for (int e = 1; e <= 32; e++) tick();
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL fix_busy got=%b exp=1", o_busy); end
    i_flush = 1'b1;
    tick();                                        // E33
    i_flush = 1'b0;
    $display("flush at E33 -> hi=%08h lo=%08h done=%b", o_hi, o_lo, o_done);
    n_cmp++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL fix_flush_ctrl got=%b%b exp=00", o_done, o_busy); end
    n_cmp++; if (o_hi !== hi_old || o_lo !== lo_old) begin n_bad++; $display("FAIL fix_flush_hilo got=%08h_%08h exp=%08h_%08h", o_hi, o_lo, hi_old, lo_old); end
  endtask

  task automatic test_back_to_back;
    logic        saw, bok;
    logic [31:0] hi, lo, eh, el;
    int          lat1, lat2;
    i_op = 3'd3; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    tick();                                        // E0
    i_start = 1'b0;
    for (int e = 1; e <= 19; e++) tick();
    rst = 1'b1;
    tick();                                        // E20
    rst = 1'b0;
    n_cmp++; if (o_hi !== 32'd0 || o_lo !== 32'd0) begin n_bad++; $display("FAIL rst_mid_hilo got=%08h_%08h exp=0_0", o_hi, o_lo); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=0", o_busy); end
    saw = 1'b0;
    for (int n = 0; n < 40; n++) begin tick(); if (o_done) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got=%b exp=0", saw); end

    run_op(3'd3, 32'd100, 32'd7, lat1, bok, hi, lo);
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_bad++; $display("FAIL b2b_first got=%08h_%08h exp=00000002_0000000e", hi, lo); end
    model(3'd3, 32'd1000, 32'd33, eh, el);
    run_op(3'd3, 32'd1000, 32'd33, lat2, bok, hi, lo);   // starts on E34
    n_cmp++; if (hi !== eh || lo !== el) begin n_bad++; $display("FAIL b2b_second got=%08h_%08h exp=%08h_%08h", hi, lo, eh, el); end
    n_cmp++; if (lat1 + 1 + lat2 !== 67) begin n_bad++; $display("FAIL b2b_done_edge got=%0d exp=67", lat1 + 1 + lat2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mt_and_noop();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 i_start  input  1  operation request, sampled on rising clk.
REQ-004 i_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 ignored (no effect).
REQ-005 i_a  input  32  rs operand: multiplicand / dividend / MTHI/MTLO source.
REQ-006 i_b  input  32  rt operand: multiplier / divisor.
REQ-007 i_flush  input  1  abort in-flight op (pipeline exception/branch flush).
REQ-008 o_busy  output  1  combinational, high while state != IDLE; pipeline stalls MFHI/MFLO/new muldiv ops on it.
REQ-009 o_done  output  1  registered one-cycle pulse on HI/LO write by MULT/MULTU/DIV/DIVU.
REQ-010 o_hi  output  32  HI register.
REQ-011 o_lo  output  32  LO register.

Function
REQ-012 FSM states: IDLE, RUN, FIX; start edge E0 = edge sampling i_start=1 in IDLE.
REQ-013 IDLE, i_start, op 0-3: latch operand magnitudes (|x| for signed ops, raw for unsigned), sign flags, and op; clear 6-bit iteration counter; go RUN.
REQ-014 RUN: one radix-2 step per edge (shift-add multiply / restoring divide) on E1..E32; after the 32nd step go FIX.
REQ-015 FIX: apply sign correction, write HI/LO on E33, go IDLE; o_done high for the cycle after E33; o_busy high exactly for the cycles between E0 and E33.
REQ-016 Multiply: {HI,LO} = 64-bit product; signed: negate 64-bit magnitude product iff operand signs differ.
REQ-017 Divide: LO = quotient, HI = remainder; signed: quotient negated iff signs differ, remainder takes dividend's sign.
REQ-018 Divisor 0 (DIV or DIVU): full latency, LO=0xFFFFFFFF, HI=i_a raw, no sign correction.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap.
REQ-020 MTHI/MTLO in IDLE: write i_a into HI/LO on E0; state stays IDLE; o_busy and o_done stay low.
REQ-021 i_start while not IDLE (any op, incl. MTHI/MTLO): ignored, no effect on in-flight op.
REQ-022 i_flush in any state: next edge state=IDLE, counter cleared, HI/LO unchanged, o_done low; i_flush with i_start in IDLE: flush wins, nothing starts.
REQ-023 i_flush on E33 (FIX state): write suppressed, HI/LO keep old values.
REQ-024 Back-to-back: new op may start on the edge after E33 (first IDLE cycle).

Reset
REQ-025 rst=1 at edge: state=IDLE, counter=0, o_hi=0, o_lo=0, o_done=0; o_busy low next cycle.
REQ-026 rst overrides i_start and i_flush; rst mid-RUN/FIX aborts with no HI/LO write and no o_done.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU computed by single-cycle combinational 32x32 multiplier, HI/LO written on E0, o_done pulse cycle after E0, o_busy never asserted for multiply; divides unchanged.
REQ-028 MULDIV_FAST_MUL_EN undefined: multiply uses iterative RUN/FIX path, 33-edge latency per REQ-015; no combinational multiplier instantiated.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_done exactly 33 edges after E0 (1 edge with MULDIV_FAST_MUL_EN).
REQ-030 MULT a=0xFFFFFFFD(-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 MTHI a=0x12345678, then DIVU 100/7 with i_flush at E10 -> o_busy low after E11, HI=0x12345678, LO unchanged, no o_done; MTLO issued at E5 of that op ignored.
REQ-033 DIVU 100/7 with rst=1 at E20 -> HI=LO=0, o_done never pulses; repeat unreset -> LO=14, HI=2, then second DIVU started on edge E34 completes at E67.
